// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Maps PS/2 key events through a runtime-loadable keymap onto player-0 buttons, merges or
//   separates joystick ports, applies per-button autofire and stretches the coin request into a
//   fixed-width pulse. Runs entirely on clk_sys.
//
// Ports:
//   clk_sys   - system clock, rising edge
//   reset_n   - synchronous active-low reset
//   ps2_key   - [10] event toggle, [9] pressed, [8:0] extended scan code
//   map_wr    - keymap write strobe
//   map_idx   - keymap entry to write
//   map_code  - scan code stored in that entry (9'h000 = unmapped)
//   joy_in    - joystick words, player p at [16p+15:16p]
//   merge     - 1: all joysticks ORed onto player 0, other groups forced to 0
//   af_mask   - autofire enable per button index
//   btn_out   - registered buttons, player p at [NUM_BTNS*p +: NUM_BTNS]
//   coin_out  - stretched coin pulse
module arcade_input_mapper #(
  parameter int unsigned NUM_BTNS     = 8,
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned COIN_IDX     = 5,
  parameter int unsigned COIN_CYCLES  = 500000,
  parameter int unsigned AUTOFIRE_DIV = 1600000,
  parameter int unsigned IW           = $clog2(NUM_BTNS)
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic [10:0]                     ps2_key,
  input  logic                            map_wr,
  input  logic [IW-1:0]                   map_idx,
  input  logic [8:0]                      map_code,
  input  logic [16*NUM_PLAYERS-1:0]       joy_in,
  input  logic                            merge,
  input  logic [NUM_BTNS-1:0]             af_mask,
  output logic [NUM_BTNS*NUM_PLAYERS-1:0] btn_out,
  output logic                            coin_out
);

  localparam int unsigned CW = $clog2(COIN_CYCLES + 1);
  localparam int unsigned DW = $clog2(AUTOFIRE_DIV + 1);
  localparam logic [CW-1:0] CoinLoad = CW'(COIN_CYCLES);
  localparam logic [DW-1:0] DivLast  = DW'(AUTOFIRE_DIV - 1);

  logic [8:0]                             keymap_q [NUM_BTNS];
  logic [NUM_BTNS-1:0]                    held_q, held_d;
  logic                                   toggle_prev_q;
  logic [DW-1:0]                          div_q;
  logic                                   phase_q;
  logic [CW-1:0]                          coin_cnt_q;
  logic                                   armed_q;
  logic [NUM_BTNS*NUM_PLAYERS-1:0]        btn_q;
  logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0]   raw, btn_d;
  logic                                   ps2_event;
  logic                                   wr_valid;
  logic                                   coin_req;
  logic                                   unused_bits;

  assign ps2_event = ps2_key[10] ^ toggle_prev_q;
  assign wr_valid  = map_wr && (32'(map_idx) < NUM_BTNS);

  // Joystick bits at or above NUM_BTNS carry nothing for this block.
  assign unused_bits = ^joy_in;

  // Event compare runs against the table as it stands before this cycle's write; a write to
  // the same entry then overrides whatever the event did to its held bit.
  always_comb begin
    held_d = held_q;
    if (ps2_event && ps2_key[8:0] != 9'h000) begin
      for (int unsigned k = 0; k < NUM_BTNS; k++) begin
        if (keymap_q[k] == ps2_key[8:0]) begin
          held_d[k] = ps2_key[9];
        end
      end
    end
    if (wr_valid) begin
      held_d[map_idx] = 1'b0;
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      raw[p] = joy_in[16*p +: NUM_BTNS];
    end
    if (merge) begin
      for (int unsigned p = 1; p < NUM_PLAYERS; p++) begin
        raw[0] = raw[0] | raw[p];
        raw[p] = '0;
      end
    end
    raw[0] = raw[0] | held_q;
  end

  // Coin request is taken ahead of autofire so a masked coin button cannot chop the pulse.
  always_comb begin
    coin_req = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      coin_req = coin_req | raw[p][COIN_IDX];
    end
  end

  always_comb begin
    btn_d = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      btn_d[p] = raw[p] & ~(af_mask & {NUM_BTNS{~phase_q}});
    end
  end

  always_ff @(posedge clk_sys) begin
    // Tracks the toggle even in reset so releasing reset never looks like a key event.
    toggle_prev_q <= ps2_key[10];
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_BTNS; k++) begin
        keymap_q[k] <= 9'h000;
      end
      held_q     <= '0;
      btn_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      coin_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      if (wr_valid) begin
        keymap_q[map_idx] <= map_code;
      end
      held_q <= held_d;
      btn_q  <= btn_d;

      if (div_q == DivLast) begin
        div_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        div_q <= div_q + DW'(1);
      end

      // armed holds off a second pulse until the request has been released after the pulse.
      if (coin_req && !armed_q && coin_cnt_q == '0) begin
        coin_cnt_q <= CoinLoad;
        armed_q    <= 1'b1;
      end else begin
        if (coin_cnt_q != '0) begin
          coin_cnt_q <= coin_cnt_q - CW'(1);
        end
        if (!coin_req && coin_cnt_q == '0) begin
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign btn_out  = btn_q;
  assign coin_out = (coin_cnt_q != '0);

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the hard-wired PS/2-plus-joystick button decode in the arcade top level.
- Maps PS/2 key events through a runtime-loadable keymap onto NUM_BTNS buttons for player 0.
- Merges or separates up to NUM_PLAYERS joysticks, adds per-button autofire and a fixed-width coin pulse.
- Sits between hps_io and the game core on clk_sys.

Parameters:
- NUM_BTNS, 8, buttons per player; joystick bit i drives button i.
- NUM_PLAYERS, 2, number of joystick ports and output button groups.
- COIN_IDX, 5, button index treated as the coin request.
- COIN_CYCLES, 500000, coin_out high time in clk_sys cycles (≥1).
- AUTOFIRE_DIV, 1600000, clk_sys cycles per autofire phase half-period (≥1).
- IW, $clog2(NUM_BTNS), keymap index width.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] extended scan code.
- map_wr  in  1  write strobe for the keymap.
- map_idx  in  IW  keymap entry to write.
- map_code  in  9  scan code for that entry; 9'h000 means unmapped.
- joy_in  in  16*NUM_PLAYERS  joystick words, player p at [16p+15:16p].
- merge  in  1  1 = all joysticks ORed onto player 0, other groups forced 0.
- af_mask  in  NUM_BTNS  autofire enable per button index.
- btn_out  out  NUM_BTNS*NUM_PLAYERS  registered button state, player p at [NUM_BTNS*p +: NUM_BTNS].
- coin_out  out  1  stretched coin pulse.

Behaviour:
- Reset (reset_n=0 at an edge):
  - Keymap entries cleared to 9'h000.
  - Key-held bits cleared; btn_out=0, coin_out=0.
  - Coin counter, coin armed flag and autofire divider/phase cleared.
  - toggle_prev loaded with ps2_key[10], so there is no spurious event on release.
  - Reset asserted mid-operation aborts any coin pulse immediately.
- PS/2 event:
  - An event is detected when ps2_key[10] != toggle_prev; toggle_prev updates every cycle.
  - On an event, every entry k with map_code[k] == ps2_key[8:0] and ps2_key[8:0] != 0 sets held[k] = ps2_key[9].
  - Duplicate codes drive all matching buttons. Unmatched codes are ignored.
  - Bit 8 (extended) participates in the compare.
- Keymap write: on an edge with map_wr=1, entry[map_idx] <= map_code and held[map_idx] <= 0.
  - If a write and an event hit the same index in one cycle, the write wins and held=0.
  - The compare uses the pre-write table contents.
  - Out-of-range map_idx is ignored.
- Raw per-player button: raw[p][i] = joy_in[16p+i].
  - Player 0 additionally ORs held[i].
  - With merge=1: raw[0][i] = held[i] | OR over p of joy_in[16p+i], and raw[p>0] = 0.
- Autofire:
  - The divider counts 0..AUTOFIRE_DIV-1, then wraps and toggles phase.
  - For af_mask[i]=1 the output is raw & phase; otherwise raw.
  - The phase starts at 0 after reset.
- Latency:
  - joy_in to btn_out is 1 cycle.
  - ps2 event to held is 1 cycle; held to btn_out is 1 more, so 2 cycles total.
- Coin:
  - coin_req = OR over p of raw[p][COIN_IDX], taken before autofire and including keyboard.
  - If coin_req=1, the armed flag is 0, and the counter is 0: load the counter with COIN_CYCLES, set armed, and drive coin_out=1 from the next cycle.
  - coin_out stays high while counter != 0; the counter decrements each cycle, giving exactly COIN_CYCLES high cycles.
  - armed clears only when coin_req=0 and the counter is 0.
  - A held coin therefore gives exactly one pulse; a re-press during the pulse is ignored.
  - btn_out still carries COIN_IDX unmodified.
- Widths: counters are sized $clog2(param+1) with no overflow; all joystick bits ≥ NUM_BTNS are ignored.

Test Plan:
- Reset then idle 100 cycles with ps2_key[10] set at reset → btn_out=0, coin_out=0, no event registered.
- Write entry 4 ← 9'h029; toggle ps2_key with pressed=1, code 029 → btn_out[4] high exactly 2 cycles after the toggle. Release toggle → low 2 cycles after.
- merge=1, joy_in player1 bit0=1 → btn_out[0]=1 and btn_out[8]=0 after 1 cycle. merge=0 → btn_out[8]=1, btn_out[0]=0.
- COIN_CYCLES=10: hold joy bit5 for 50 cycles → coin_out high for exactly 10 cycles, one pulse. Release, press again → second 10-cycle pulse.
- AUTOFIRE_DIV=4, af_mask[0]=1, hold bit0 → btn_out[0] alternates 4 low / 4 high. af_mask=0 → steady high.
- Same-cycle map_wr to index 4 and a press event for entry 4's old code → held[4]=0. Assert reset_n=0 mid coin pulse → coin_out=0 next cycle.
